tone_player: RTL
================

Name: tone_player

Overview:
- Downstream consumer of the note-to-divider lookup: takes a 17-bit half-period count N plus a note duration and drives a square-wave tone onto the buzzer pin.
- Plays one note per handshake. Holds the tone for the requested number of milliseconds, then inserts a fixed silent gap so that repeated notes are audibly separated.
- Sits between the song sequencer, which supplies note indices and durations, and the board buzzer output.

Parameters:
- MS_TICKS, 50000: clock cycles per millisecond (50 MHz clock).
- DUR_W, 8: width of the duration field, in ms units.
- GAP_MS, 10: silent gap after each note, in ms; 0 disables the gap.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a note request is present.
- in_ready  out  1  block can accept a request.
- in_n  in  17  half-period count in clk cycles; 0 means rest (silence).
- in_dur  in  DUR_W  note length in ms.
- tone  out  1  square-wave buzzer drive.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a note (including its gap) completes.

Behaviour:
- Reset, asynchronous and active-low:
  - state = IDLE; tone = 0, done = 0, busy = 0, in_ready = 1.
  - All counters are cleared.
  - Reset mid-note aborts immediately: no done pulse and no residual tone.
- States: IDLE, PLAY, GAP.
- in_ready = (state == IDLE), combinational from the state register.
- Accept:
  - A request is accepted on a rising edge where in_valid && in_ready. Call that edge cycle 0.
  - in_n and in_dur are latched; the ms prescaler and the half-period counter are cleared; tone is set to 0.
  - in_n and in_dur are don't-care at all other times.
- Transitions:
  - From IDLE on accept:
    - in_dur != 0: go to PLAY.
    - in_dur == 0 and GAP_MS != 0: go to GAP.
    - in_dur == 0 and GAP_MS == 0: stay in IDLE and pulse done at cycle 1.
  - PLAY lasts exactly in_dur * MS_TICKS cycles (cycles 1 .. in_dur*MS_TICKS), then goes to GAP, or to IDLE if GAP_MS == 0.
  - GAP lasts exactly GAP_MS * MS_TICKS cycles, then goes to IDLE.
- done:
  - High for exactly the first cycle back in IDLE.
  - Because in_ready is also 1 in that cycle, a back-to-back accept is allowed in it.
- Tone generation, PLAY only:
  - The half-period counter counts 0 .. N-1.
  - When the counter is at N-1, tone toggles and the counter returns to 0. The first toggle therefore takes effect at cycle N+1.
  - N = 1 toggles every cycle (legal).
  - N = 0: tone is held at 0 for the whole PLAY duration.
- tone is forced to 0 in IDLE and GAP, and on the PLAY-to-GAP/IDLE exit edge, so a note never ends high.
- Timing:
  - The ms prescaler counts 0 .. MS_TICKS-1 and emits a tick at MS_TICKS-1.
  - The remaining-ms counter (DUR_W bits) decrements on each tick; PLAY exits on the tick that brings it to 0.
  - The GAP counter uses the same tick.
- Widths:
  - Counters use unsigned arithmetic.
  - The half-period counter is 17 bits, compared with the latched N.
  - The prescaler is $clog2(MS_TICKS) bits.
  - No overflow is possible for legal parameters.
- Simultaneous events: in_valid asserted while busy is ignored (in_ready = 0). The requester must hold in_n and in_dur stable until it is accepted.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, PLAY, GAP);
  - the N width constant, 17;
  - default MS_TICKS and GAP_MS.
- One sub-module, ms_tick:
  - prescaler with a synchronous clear input;
  - one-cycle tick output every MS_TICKS cycles;
  - instantiated once and shared by the PLAY and GAP timing.

Test Plan:
All scenarios use MS_TICKS=10 and GAP_MS=1.
- Reset: assert rst_n=0 mid-PLAY -> tone, busy and done go to 0 and in_ready to 1 asynchronously, without waiting for a clock edge. After release, the next accept plays normally.
- Basic note: in_n=3, in_dur=2 accepted at cycle 0 ->
  - busy high for cycles 1-30;
  - tone toggles at cycles 4, 7, 10, 13, 16, 19 (6 toggles within PLAY, cycles 1-20);
  - tone is 0 during cycles 21-30;
  - done=1 only in cycle 31.
- Rest: in_n=0, in_dur=3 -> tone stays 0 for all 30 PLAY cycles plus the 10-cycle GAP; done at cycle 41.
- Zero duration: in_dur=0 -> no PLAY; GAP for cycles 1-10; done at cycle 11. Repeat with GAP_MS=0 -> done at cycle 1.
- Back-to-back: in_valid held high with in_n=1, in_dur=1 -> each accept lands exactly on the done cycle; tone toggles every cycle during each PLAY; no request is dropped or duplicated over 4 notes.
- Busy ignore: pulse in_valid with in_n=5 during PLAY of an in_n=2 note -> the request is not accepted, and the tone period stays 2 cycles per level for the current note.

Source files
------------

// File: rtl/tone_player_pkg.sv
// Shared types and constants for the tone player: state encoding, note width
// and default timing parameters.
package tone_player_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int N_W            = 17;
    localparam int DEF_MS_TICKS   = 50000;
    localparam int DEF_GAP_MS     = 10;

endpackage

// File: rtl/tone_player_if.sv
// Note request handshake between the song sequencer and the tone player.
interface tone_player_if #(
    parameter int DUR_W = 8
);
    logic                           in_valid;
    logic                           in_ready;
    logic [tone_player_pkg::N_W-1:0] in_n;
    logic [DUR_W-1:0]               in_dur;

    modport master (output in_valid, in_n, in_dur, input in_ready);
    modport slave  (input in_valid, in_n, in_dur, output in_ready);
endinterface

// File: rtl/tone_player_ms_tick.sv
// Millisecond prescaler: one-cycle tick every MS_TICKS clocks, restartable
// through a synchronous clear.
module ms_tick
    import tone_player_pkg::*;
#(
    parameter int MS_TICKS = DEF_MS_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(MS_TICKS - 1));

    // NOTE: clocked state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/tone_player.sv
// Plays one square-wave note per handshake for a given number of milliseconds,
// followed by a fixed silent gap, then pulses done.
module tone_player
    import tone_player_pkg::*;
#(
    parameter int MS_TICKS = DEF_MS_TICKS,
    parameter int DUR_W    = 8,
    parameter int GAP_MS   = DEF_GAP_MS
) (
    input  logic          clk,
    input  logic          rst_n,
    tone_player_if.slave  bus,
    output logic          tone,
    output logic          busy,
    output logic          done
);
    localparam int GAP_W   = $clog2(GAP_MS + 2);
    localparam bit HAS_GAP = (GAP_MS != 0);

    state_t           state_q, state_d;
    logic             done_q, done_d;
    logic [N_W-1:0]   n_q, hp_q;
    logic [DUR_W-1:0] rem_q;
    logic [GAP_W-1:0] gap_q;
    logic             tone_q;
    logic             accept, tick, play_exit, gap_exit;

    assign bus.in_ready = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign tone         = tone_q;
    assign done         = done_q;

    assign accept    = bus.in_valid && (state_q == IDLE);
    assign play_exit = (state_q == PLAY) && tick && (rem_q == DUR_W'(1));
    assign gap_exit  = (state_q == GAP)  && tick && (gap_q == GAP_W'(1));

    // Held in clear while idle, so the first PLAY/GAP cycle starts a fresh millisecond.
    ms_tick #(.MS_TICKS(MS_TICKS)) u_ms_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.in_dur != '0) begin
                        state_d = PLAY;
                    end else if (HAS_GAP) begin
                        state_d = GAP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (play_exit) begin
                    if (HAS_GAP) begin
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_exit) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q    <= '0;
            hp_q   <= '0;
            rem_q  <= '0;
            gap_q  <= '0;
            tone_q <= 1'b0;
        end else if (accept) begin
            n_q    <= bus.in_n;
            rem_q  <= bus.in_dur;
            gap_q  <= GAP_W'(GAP_MS);
            hp_q   <= '0;
            tone_q <= 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (tick) begin
                        rem_q <= rem_q - DUR_W'(1);
                    end
                    // The exit edge wins over a toggle so a note never ends high.
                    if (play_exit) begin
                        tone_q <= 1'b0;
                        hp_q   <= '0;
                    end else if (n_q != '0) begin
                        if (hp_q == n_q - N_W'(1)) begin
                            tone_q <= ~tone_q;
                            hp_q   <= '0;
                        end else begin
                            hp_q <= hp_q + N_W'(1);
                        end
                    end
                end
                GAP: begin
                    tone_q <= 1'b0;
                    if (tick) begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: tone_q <= 1'b0;
            endcase
        end
    end
endmodule
